prob_percent_reporter: RTL and testbench

Sequential, parametrised converter that accepts one vector of N_CLS class probabilities (unsigned Q-format, FRAC fractional bits) per handshake from the MLP output stage. It streams each class's 0–100 % value on a valid/ready port in class order. It selects the winning class (argmax) and reports it with its percentage on a one-cycle result pulse. It sits between the MLP softmax/sigmoid output and the display/UART reporting logic, and replaces per-class combinational percent conversion with one shared converter.

---
 rtl/prob_percent_reporter_pkg.sv | 16 +
 rtl/prob_pct_conv.sv | 28 ++
 rtl/prob_percent_reporter.sv | 133 +++++++++++++
 tb/tb_prob_percent_reporter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/prob_percent_reporter_pkg.sv
// Shared constants and FSM state type for the probability-to-percent reporter.
package prob_percent_reporter_pkg;

  localparam int PCT_MAX = 100;
  localparam int PCT_W   = 7;

  localparam int ROUND_TRUNC    = 0;
  localparam int ROUND_HALF_UP  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/prob_pct_conv.sv
// Combinational Q-format probability to 0..100 percent converter with clamp.
module prob_pct_conv
  import prob_percent_reporter_pkg::*;
#(
  parameter int W     = 8,
  parameter int FRAC  = 6,
  parameter int ROUND = ROUND_HALF_UP
) (
  input  logic [W-1:0]     p_q,
  output logic [PCT_W-1:0] pct,
  output logic             sat
);

  // One bit wider than p*100 so the rounding bias can never wrap.
  localparam int SW = W + 8;
  localparam logic [SW-1:0] BIAS = (ROUND == ROUND_HALF_UP) ? (SW'(1) << (FRAC - 1)) : '0;

  logic [SW-1:0] scaled;
  logic [SW-1:0] shifted;

  always_comb begin
    scaled  = SW'(p_q) * SW'(PCT_MAX) + BIAS;
    shifted = scaled >> FRAC;
    sat     = shifted > SW'(PCT_MAX);
    pct     = sat ? PCT_W'(PCT_MAX) : shifted[PCT_W-1:0];
  end

endmodule

// File: rtl/prob_percent_reporter.sv
// Streams per-class percentages of a captured probability vector through one
// shared converter and reports the argmax class with its percentage.
module prob_percent_reporter
  import prob_percent_reporter_pkg::*;
#(
  parameter int W     = 8,
  parameter int FRAC  = 6,
  parameter int N_CLS = 2,
  parameter int ROUND = 1,
  localparam int CLS_W = $clog2(N_CLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CLS*W-1:0]   in_probs,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CLS_W-1:0]     out_cls,
  output logic [PCT_W-1:0]     out_pct,
  output logic                 out_sat,
  output logic                 out_last,
  output logic                 res_valid,
  output logic [CLS_W-1:0]     res_cls,
  output logic [PCT_W-1:0]     res_pct
);

  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(N_CLS - 1);

  state_t state, state_nxt;

  logic [W-1:0]       probs [N_CLS];
  logic [CLS_W-1:0]   idx;
  logic [W-1:0]       best_q;
  logic [CLS_W-1:0]   best_idx;
  logic [PCT_W-1:0]   best_pct;

  logic [W-1:0]       cur_q;
  logic [PCT_W-1:0]   conv_pct;
  logic               conv_sat;
  logic               accept;
  logic               emit_hs;
  logic               take_cur;
  logic [CLS_W-1:0]   win_idx;
  logic [PCT_W-1:0]   win_pct;

  assign cur_q = probs[idx];

  prob_pct_conv #(
    .W     (W),
    .FRAC  (FRAC),
    .ROUND (ROUND)
  ) u_conv (
    .p_q (cur_q),
    .pct (conv_pct),
    .sat (conv_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    state_nxt = EMIT;
      EMIT:    if (emit_hs) state_nxt = out_last ? IDLE : CALC;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == EMIT);
  end

  assign accept  = in_valid & in_ready;
  assign emit_hs = out_valid & out_ready;

  // out_pct was converted from probs[idx], which is stable through EMIT.
  assign take_cur = (idx == '0) || (cur_q > best_q);
  assign win_idx  = take_cur ? idx : best_idx;
  assign win_pct  = take_cur ? out_pct : best_pct;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CLS; i++) probs[i] <= '0;
      idx       <= '0;
      best_q    <= '0;
      best_idx  <= '0;
      best_pct  <= '0;
      out_cls   <= '0;
      out_pct   <= '0;
      out_sat   <= 1'b0;
      out_last  <= 1'b0;
      res_valid <= 1'b0;
      res_cls   <= '0;
      res_pct   <= '0;
    end else begin
      res_valid <= 1'b0;
      if (accept) begin
        for (int unsigned i = 0; i < N_CLS; i++) probs[i] <= in_probs[i*W +: W];
        idx      <= '0;
        best_q   <= '0;
        best_idx <= '0;
        best_pct <= '0;
      end
      if (state == CALC) begin
        out_cls  <= idx;
        out_pct  <= conv_pct;
        out_sat  <= conv_sat;
        out_last <= (idx == LAST_IDX);
      end
      if (emit_hs) begin
        if (take_cur) begin
          best_q   <= cur_q;
          best_idx <= idx;
          best_pct <= out_pct;
        end
        if (out_last) begin
          res_valid <= 1'b1;
          res_cls   <= win_idx;
          res_pct   <= win_pct;
        end else begin
          idx <= idx + CLS_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_prob_percent_reporter.sv
// Directed bench: two 2-class instances (round / truncate) in lockstep and a 4-class instance.
module tb_prob_percent_reporter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v2 = 1'b0, v4 = 1'b0, rdy = 1'b1;
  logic [15:0] p2 = '0;
  logic [31:0] p4 = '0;

  logic       a_in_ready, a_out_valid, a_out_cls, a_out_sat, a_out_last, a_res_valid, a_res_cls;
  logic [6:0] a_out_pct, a_res_pct;
  logic       t_in_ready, t_out_valid, t_out_cls, t_out_sat, t_out_last, t_res_valid, t_res_cls;
  logic [6:0] t_out_pct, t_res_pct;
  logic       q_in_ready, q_out_valid, q_out_sat, q_out_last, q_res_valid;
  logic [1:0] q_out_cls, q_res_cls;
  logic [6:0] q_out_pct, q_res_pct;

  prob_percent_reporter #(.W(8), .FRAC(6), .N_CLS(2), .ROUND(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(a_in_ready), .in_probs(p2),
    .out_valid(a_out_valid), .out_ready(rdy), .out_cls(a_out_cls), .out_pct(a_out_pct),
    .out_sat(a_out_sat), .out_last(a_out_last), .res_valid(a_res_valid),
    .res_cls(a_res_cls), .res_pct(a_res_pct));

  prob_percent_reporter #(.W(8), .FRAC(6), .N_CLS(2), .ROUND(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(t_in_ready), .in_probs(p2),
    .out_valid(t_out_valid), .out_ready(rdy), .out_cls(t_out_cls), .out_pct(t_out_pct),
    .out_sat(t_out_sat), .out_last(t_out_last), .res_valid(t_res_valid),
    .res_cls(t_res_cls), .res_pct(t_res_pct));

  prob_percent_reporter #(.W(8), .FRAC(6), .N_CLS(4), .ROUND(1)) dut_q (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(q_in_ready), .in_probs(p4),
    .out_valid(q_out_valid), .out_ready(rdy), .out_cls(q_out_cls), .out_pct(q_out_pct),
    .out_sat(q_out_sat), .out_last(q_out_last), .res_valid(q_res_valid),
    .res_cls(q_res_cls), .res_pct(q_res_pct));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef logic [7:0] vec4_t [4];
  typedef int         int4_t [4];

  task automatic run(input string tag, input bit four, input vec4_t p, input int4_t ep,
                     input int4_t es, input int4_t et, input int rc, input int rp, input int rtp);
    int n, k, nc;
    nc = four ? 4 : 2;
    @(negedge clk);
    check({tag, "_in_ready"}, four ? q_in_ready : a_in_ready, 1);
    if (!four) check({tag, "_t_in_ready"}, t_in_ready, 1);
    if (four) begin p4 = {p[3], p[2], p[1], p[0]}; v4 = 1'b1; end
    else      begin p2 = {p[1], p[0]};             v2 = 1'b1; end
    @(posedge clk); #1;
    v2 = 1'b0; v4 = 1'b0;
    n = 0; k = 0;
    while (k < nc && n < 40) begin
      @(negedge clk); n++;
      if (four ? q_out_valid : a_out_valid) begin
        if (k == 0) check({tag, "_latency"}, n, 2);
        check({tag, "_cls"},  four ? q_out_cls  : a_out_cls,  k);
        check({tag, "_pct"},  four ? q_out_pct  : a_out_pct,  ep[k]);
        check({tag, "_sat"},  four ? q_out_sat  : a_out_sat,  es[k]);
        check({tag, "_last"}, four ? q_out_last : a_out_last, (k == nc - 1) ? 1 : 0);
        if (!four) begin
          check({tag, "_t_valid"}, t_out_valid, 1);
          check({tag, "_t_cls"},   t_out_cls, k);
          check({tag, "_t_pct"},   t_out_pct, et[k]);
          check({tag, "_t_sat"},   t_out_sat, (et[k] > 100) ? 1 : es[k]);
          check({tag, "_t_last"},  t_out_last, (k == nc - 1) ? 1 : 0);
        end
        k++;
      end
    end
    if (k < nc) check({tag, "_timeout"}, k, nc);
    @(negedge clk);
    check({tag, "_res_valid"}, four ? q_res_valid : a_res_valid, 1);
    check({tag, "_res_cls"},   four ? q_res_cls   : a_res_cls,   rc);
    check({tag, "_res_pct"},   four ? q_res_pct   : a_res_pct,   rp);
    check({tag, "_idle"},      four ? q_in_ready  : a_in_ready,  1);
    if (!four) begin
      check({tag, "_t_res_valid"}, t_res_valid, 1);
      check({tag, "_t_res_cls"},   t_res_cls, rc);
      check({tag, "_t_res_pct"},   t_res_pct, rtp);
    end
    @(negedge clk);
    check({tag, "_res_pulse"}, four ? q_res_valid : a_res_valid, 0);
    check({tag, "_res_hold"},  four ? q_res_pct   : a_res_pct,   rp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, cnt;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_pct",   a_out_pct, 0);
    check("rst_res_valid", a_res_valid, 0);
    check("rst_q_out_cls", q_out_cls, 0);
    check("rst_q_res_pct", q_res_pct, 0);
    rst_n = 1'b1;

    run("basic", 1'b0, '{8'd16, 8'd48, 8'd0, 8'd0}, '{25, 75, 0, 0}, '{0, 0, 0, 0},
        '{25, 75, 0, 0}, 1, 75, 75);
    run("rnd_small", 1'b0, '{8'd1, 8'd33, 8'd0, 8'd0}, '{2, 52, 0, 0}, '{0, 0, 0, 0},
        '{1, 51, 0, 0}, 1, 52, 51);
    run("one", 1'b0, '{8'd64, 8'd0, 8'd0, 8'd0}, '{100, 0, 0, 0}, '{0, 0, 0, 0},
        '{100, 0, 0, 0}, 0, 100, 100);
    run("clamp", 1'b0, '{8'd255, 8'd200, 8'd0, 8'd0}, '{100, 100, 0, 0}, '{1, 1, 0, 0},
        '{100, 100, 0, 0}, 0, 100, 100);
    run("tie4", 1'b1, '{8'd10, 8'd40, 8'd40, 8'd5}, '{16, 63, 63, 8}, '{0, 0, 0, 0},
        '{0, 0, 0, 0}, 1, 63, 0);

    // Backpressure: stall class 0 for 5 cycles while poking in_valid with other data.
    rdy = 1'b0;
    @(negedge clk);
    p2 = {8'd48, 8'd16}; v2 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0;
    n = 0;
    while (!a_out_valid && n < 10) begin @(negedge clk); n++; end
    check("bp_reach", a_out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",    a_out_valid, 1);
      check("bp_cls",      a_out_cls, 0);
      check("bp_pct",      a_out_pct, 25);
      check("bp_in_ready", a_in_ready, 0);
      p2 = {8'd200, 8'd200};
      v2 = (i % 2 == 0);
      @(negedge clk);
    end
    v2 = 1'b0; rdy = 1'b1;
    @(negedge clk);
    n = 0;
    while (!(a_out_valid && a_out_cls == 1'b1) && n < 10) begin @(negedge clk); n++; end
    check("bp_c1_valid", a_out_valid, 1);
    check("bp_c1_pct",   a_out_pct, 75);
    check("bp_c1_sat",   a_out_sat, 0);
    @(negedge clk);
    check("bp_res_valid", a_res_valid, 1);
    check("bp_res_cls",   a_res_cls, 1);
    check("bp_res_pct",   a_res_pct, 75);

    // Asynchronous reset while class 1 of a 4-class vector is presented.
    @(negedge clk);
    p4 = {8'd5, 8'd40, 8'd40, 8'd10}; v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0;
    n = 0;
    while (!(q_out_valid && q_out_cls == 2'd1) && n < 20) begin @(negedge clk); n++; end
    check("ar_reach", q_out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", q_out_valid, 0);
    check("ar_out_cls",   q_out_cls, 0);
    check("ar_out_pct",   q_out_pct, 0);
    check("ar_out_sat",   q_out_sat, 0);
    check("ar_out_last",  q_out_last, 0);
    check("ar_res_valid", q_res_valid, 0);
    check("ar_res_cls",   q_res_cls, 0);
    check("ar_res_pct",   q_res_pct, 0);
    check("ar_in_ready",  q_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin @(negedge clk); if (q_res_valid) cnt++; end
    check("ar_no_res", cnt, 0);

    run("after_rst", 1'b1, '{8'd10, 8'd40, 8'd40, 8'd5}, '{16, 63, 63, 8}, '{0, 0, 0, 0},
        '{0, 0, 0, 0}, 1, 63, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
